// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and helpers for the CPU pipeline writeback stage.
//   wb_state_t   : writeback stage FSM states (idle / waiting on a load)
//   BYTE_W       : width of a byte load
//   MAX_DATA_W   : widest datapath load_extend() can serve
//   load_extend(): sign/zero extension of a load result
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 64;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT
  } wb_state_t;

  // Works on the widest supported datapath; callers zero-extend their data in
  // and truncate the result back to their own width. Truncation keeps the
  // correct low bits because the extension only ever affects the upper bits.
  function automatic logic [MAX_DATA_W-1:0] load_extend(
    input logic [MAX_DATA_W-1:0] data,
    input logic                  is_byte,
    input logic                  is_signed
  );
    logic [MAX_DATA_W-1:0] result;
    if (is_byte) begin
      result = {{(MAX_DATA_W-BYTE_W){is_signed & data[BYTE_W-1]}}, data[BYTE_W-1:0]};
    end else begin
      result = data;
    end
    return result;
  endfunction

endpackage

// File: rtl/load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational load-data formatter shared by the immediate and delayed load
// paths of the writeback stage.
// Ports:
//   data      in  DATA_W  raw load data from data memory
//   is_byte   in  1       load is 8-bit (else full width)
//   is_signed in  1       sign-extend a byte load (else zero-extend)
//   result    out DATA_W  extended load value
// -----------------------------------------------------------------------------
module load_extender
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic              is_byte,
  input  logic              is_signed,
  output logic [DATA_W-1:0] result
);

  assign result = DATA_W'(load_extend(MAX_DATA_W'(data), is_byte, is_signed));

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Registered MEM/WB pipeline stage. Selects the register-file writeback value
// from the ALU result, a (sign/zero-extended) data-memory load, or the
// semaphore read bit. Loads whose data is not returned in the accept cycle
// park the stage in WB_WAIT and stall the pipeline until dmem_rvalid arrives
// or the optional timeout expires.
//
// Optional feature macro: WB_FORWARD_EN
//   Adds fwd_valid/fwd_data, a combinational bypass of the value that will be
//   written at the next edge, for EX-stage forwarding.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   suspend_cpu                 global freeze, all state holds
//   mem_*                       MEM-stage instruction and its control bits
//   dmem_rvalid, dmem_rdata     data-memory read return
//   wb_regfile_writeback        registered writeback value
//   wb_rd_id                    registered destination register
//   wb_reg_write                one-cycle register-file write strobe
//   wb_stall                    load outstanding, upstream must hold
//   wb_load_timeout             sticky load-timeout error flag
//   fwd_valid, fwd_data         (WB_FORWARD_EN only) same-cycle bypass
// -----------------------------------------------------------------------------
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_ID_W     = 4,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                suspend_cpu,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_alu_result,
  input  logic [REG_ID_W-1:0] mem_rd_id,
  input  logic                mem_reg_write,
  input  logic                mem_mem_to_reg,
  input  logic                mem_load_byte,
  input  logic                mem_load_signed,
  input  logic                mem_sema_read_performed,
  input  logic                mem_sema_writeback,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic [DATA_W-1:0]   wb_regfile_writeback,
  output logic [REG_ID_W-1:0] wb_rd_id,
  output logic                wb_reg_write,
  output logic                wb_stall,
  output logic                wb_load_timeout
`ifdef WB_FORWARD_EN
  ,
  output logic                fwd_valid,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  // The counter runs 0 .. LOAD_TIMEOUT-1 across the WAIT cycles; the timeout
  // fires in the WAIT cycle where it holds CNT_LAST.
  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

  wb_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ID_W-1:0]   lat_rd_id_q, lat_rd_id_d;
  logic                  lat_reg_write_q, lat_reg_write_d;
  logic                  lat_byte_q, lat_byte_d;
  logic                  lat_signed_q, lat_signed_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [REG_ID_W-1:0]   rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  timeout_q, timeout_d;
  logic                  stall;

  logic                  is_load;
  logic                  ext_byte;
  logic                  ext_signed;
  logic [DATA_W-1:0]     load_data;

  assign is_load = mem_mem_to_reg & ~mem_sema_read_performed;

  // One extender serves both paths: in WAIT the MEM-stage controls have moved
  // on, so the latched copies steer the extension instead.
  assign ext_byte   = (state_q == WB_WAIT) ? lat_byte_q   : mem_load_byte;
  assign ext_signed = (state_q == WB_WAIT) ? lat_signed_q : mem_load_signed;

  load_extender #(
    .DATA_W(DATA_W)
  ) u_load_extender (
    .data     (dmem_rdata),
    .is_byte  (ext_byte),
    .is_signed(ext_signed),
    .result   (load_data)
  );

  always_comb begin
    // NOTE: every next-state variable is given its hold value first, so no
    // branch can leave one unassigned and infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    lat_rd_id_d     = lat_rd_id_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_byte_d      = lat_byte_q;
    lat_signed_d    = lat_signed_q;
    data_d          = data_q;
    rd_d            = rd_q;
    rw_d            = 1'b0;
    timeout_d       = timeout_q;
    stall           = 1'b0;

    if (suspend_cpu) begin
      // Frozen: everything holds, the write strobe stays low.
      stall = (state_q == WB_WAIT);
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (mem_valid) begin
            if (!is_load) begin
              data_d = mem_mem_to_reg ? DATA_W'(mem_sema_writeback) : mem_alu_result;
              rd_d   = mem_rd_id;
              rw_d   = mem_reg_write;
            end else if (dmem_rvalid) begin
              data_d = load_data;
              rd_d   = mem_rd_id;
              rw_d   = mem_reg_write;
            end else begin
              lat_rd_id_d     = mem_rd_id;
              lat_reg_write_d = mem_reg_write;
              lat_byte_d      = mem_load_byte;
              lat_signed_d    = mem_load_signed;
              cnt_d           = '0;
              state_d         = WB_WAIT;
              stall           = 1'b1;
            end
          end
        end
        WB_WAIT: begin
          if (dmem_rvalid) begin
            data_d  = load_data;
            rd_d    = lat_rd_id_q;
            rw_d    = lat_reg_write_q;
            cnt_d   = '0;
            state_d = WB_IDLE;
          end else begin
            stall = 1'b1;
            if ((LOAD_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
              timeout_d = 1'b1;
              cnt_d     = '0;
              state_d   = WB_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= WB_IDLE;
      cnt_q           <= '0;
      lat_rd_id_q     <= '0;
      lat_reg_write_q <= 1'b0;
      lat_byte_q      <= 1'b0;
      lat_signed_q    <= 1'b0;
      data_q          <= '0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values and the stage updates as one.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lat_rd_id_q     <= lat_rd_id_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_byte_q      <= lat_byte_d;
      lat_signed_q    <= lat_signed_d;
      data_q          <= data_d;
      rd_q            <= rd_d;
      rw_q            <= rw_d;
      timeout_q       <= timeout_d;
    end
  end

  assign wb_regfile_writeback = data_q;
  assign wb_rd_id             = rd_q;
  // A strobe registered just before a freeze must not reach the register file
  // while frozen; rw_d is also low under suspend so it cannot reappear later.
  assign wb_reg_write         = rw_q & ~suspend_cpu;
  // Stall is combinational from the MEM inputs in IDLE, so reset must mask it.
  assign wb_stall             = stall & ~rst;
  assign wb_load_timeout      = timeout_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid = rw_d & ~rst;
  assign fwd_data  = data_d;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int DATA_W       = 16;
  localparam int REG_ID_W     = 4;
  localparam int LOAD_TIMEOUT = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                suspend_cpu = 1'b0;
  logic                mem_valid;
  logic [DATA_W-1:0]   mem_alu_result;
  logic [REG_ID_W-1:0] mem_rd_id;
  logic                mem_reg_write;
  logic                mem_mem_to_reg;
  logic                mem_load_byte;
  logic                mem_load_signed;
  logic                mem_sema_read_performed;
  logic                mem_sema_writeback;
  logic                dmem_rvalid;
  logic [DATA_W-1:0]   dmem_rdata;
  logic [DATA_W-1:0]   wb_regfile_writeback;
  logic [REG_ID_W-1:0] wb_rd_id;
  logic                wb_reg_write;
  logic                wb_stall;
  logic                wb_load_timeout;
`ifdef WB_FORWARD_EN
  logic                fwd_valid;
  logic [DATA_W-1:0]   fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_stage #(
    .DATA_W      (DATA_W),
    .REG_ID_W    (REG_ID_W),
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .suspend_cpu            (suspend_cpu),
    .mem_valid              (mem_valid),
    .mem_alu_result         (mem_alu_result),
    .mem_rd_id              (mem_rd_id),
    .mem_reg_write          (mem_reg_write),
    .mem_mem_to_reg         (mem_mem_to_reg),
    .mem_load_byte          (mem_load_byte),
    .mem_load_signed        (mem_load_signed),
    .mem_sema_read_performed(mem_sema_read_performed),
    .mem_sema_writeback     (mem_sema_writeback),
    .dmem_rvalid            (dmem_rvalid),
    .dmem_rdata             (dmem_rdata),
    .wb_regfile_writeback   (wb_regfile_writeback),
    .wb_rd_id               (wb_rd_id),
    .wb_reg_write           (wb_reg_write),
    .wb_stall               (wb_stall),
    .wb_load_timeout        (wb_load_timeout)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid              (fwd_valid),
    .fwd_data               (fwd_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [REG_ID_W-1:0] rd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_reg_write === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got data=%h rd=%0d, required no write",
                 wb_regfile_writeback, wb_rd_id);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_regfile_writeback !== mon_e.data || wb_rd_id !== mon_e.rd) begin
          n_fail++;
          $display("FAIL sb_write: got data=%h rd=%0d, required data=%h rd=%0d",
                   wb_regfile_writeback, wb_rd_id, mon_e.data, mon_e.rd);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    mem_valid               = 1'b0;
    mem_alu_result          = '0;
    mem_rd_id               = '0;
    mem_reg_write           = 1'b0;
    mem_mem_to_reg          = 1'b0;
    mem_load_byte           = 1'b0;
    mem_load_signed         = 1'b0;
    mem_sema_read_performed = 1'b0;
    mem_sema_writeback      = 1'b0;
    dmem_rvalid             = 1'b0;
    dmem_rdata              = '0;
  endtask

  task automatic drive_alu(input logic [DATA_W-1:0] d, input logic [REG_ID_W-1:0] rd,
                           input logic rw);
    set_idle();
    mem_valid      = 1'b1;
    mem_alu_result = d;
    mem_rd_id      = rd;
    mem_reg_write  = rw;
  endtask

  task automatic drive_load(input logic [REG_ID_W-1:0] rd, input logic is_byte,
                            input logic is_signed, input logic rvalid,
                            input logic [DATA_W-1:0] rdata);
    set_idle();
    mem_valid       = 1'b1;
    mem_mem_to_reg  = 1'b1;
    mem_rd_id       = rd;
    mem_reg_write   = 1'b1;
    mem_load_byte   = is_byte;
    mem_load_signed = is_signed;
    dmem_rvalid     = rvalid;
    dmem_rdata      = rdata;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wb_regfile_writeback, wb_rd_id, wb_reg_write, wb_stall, wb_load_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wb=%h rd=%0d we=%b stall=%b to=%b, required all 0",
               wb_regfile_writeback, wb_rd_id, wb_reg_write, wb_stall, wb_load_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_write();
    @(posedge clk); #1;
    drive_alu(16'h1234, 4'd5, 1'b1);
    exp_q.push_back(wr_t'{16'h1234, 4'd5});
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL alu_stall: got %b, required 0", wb_stall);
    end
    // mem_valid low with live-looking fields: must not write or update.
    @(posedge clk); #1;
    set_idle();
    mem_alu_result = 16'hFFFF; mem_rd_id = 4'hF; mem_reg_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h1234 || wb_rd_id !== 4'd5 || wb_reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_result: got wb=%h rd=%0d we=%b, required wb=1234 rd=5 we=1",
               wb_regfile_writeback, wb_rd_id, wb_reg_write);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h1234 || wb_rd_id !== 4'd5 || wb_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_hold_invalid: got wb=%h rd=%0d we=%b, required wb=1234 rd=5 we=0",
               wb_regfile_writeback, wb_rd_id, wb_reg_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0]   d, pd;
    logic [REG_ID_W-1:0] r, pr;
    logic                w, pw;
    pd = '0; pr = '0; pw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = DATA_W'($urandom);
      r = REG_ID_W'(i + 10);
      w = (i % 3 != 1);
      @(posedge clk); #1;
      drive_alu(d, r, w);
      if (w) exp_q.push_back(wr_t'{d, r});
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (wb_reg_write !== pw || wb_regfile_writeback !== pd || wb_rd_id !== pr) begin
          n_fail++;
          $display("FAIL b2b_op%0d: got wb=%h rd=%0d we=%b, required wb=%h rd=%0d we=%b",
                   i - 1, wb_regfile_writeback, wb_rd_id, wb_reg_write, pd, pr, pw);
        end
      end
      pd = d; pr = r; pw = w;
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_reg_write !== pw || wb_regfile_writeback !== pd || wb_rd_id !== pr) begin
      n_fail++;
      $display("FAIL b2b_last: got wb=%h rd=%0d we=%b, required wb=%h rd=%0d we=%b",
               wb_regfile_writeback, wb_rd_id, wb_reg_write, pd, pr, pw);
    end
  endtask

  task automatic test_semaphore();
    @(posedge clk); #1;
    drive_alu(16'hABCD, 4'd3, 1'b1);
    mem_mem_to_reg = 1'b1; mem_sema_read_performed = 1'b1; mem_sema_writeback = 1'b1;
    mem_load_byte = 1'b1;
    exp_q.push_back(wr_t'{16'h0001, 4'd3});
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL sema_stall: got %b, required 0", wb_stall);
    end
    @(posedge clk); #1;
    drive_alu(16'hABCD, 4'd6, 1'b1);
    mem_mem_to_reg = 1'b1; mem_sema_read_performed = 1'b1; mem_sema_writeback = 1'b0;
    exp_q.push_back(wr_t'{16'h0000, 4'd6});
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0001) begin
      n_fail++; $display("FAIL sema_one: got %h, required 0001", wb_regfile_writeback);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0000) begin
      n_fail++; $display("FAIL sema_zero: got %h, required 0000", wb_regfile_writeback);
    end
  endtask

  task automatic test_load_immediate();
    logic [DATA_W-1:0] rdata[4] = '{16'h0080, 16'h1234, 16'hBEEF, 16'hAB80};
    logic              byt[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic              sgn[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [DATA_W-1:0] expd[4]  = '{16'h0080, 16'h0034, 16'hBEEF, 16'hFF80};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_load(REG_ID_W'(i + 1), byt[i], sgn[i], 1'b1, rdata[i]);
      exp_q.push_back(wr_t'{expd[i], REG_ID_W'(i + 1)});
      @(negedge clk);
      n_checks++;
      if (wb_stall !== 1'b0) begin
        n_fail++; $display("FAIL load_imm%0d_stall: got %b, required 0", i, wb_stall);
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'hFF80 || wb_rd_id !== 4'd4) begin
      n_fail++;
      $display("FAIL load_imm_last: got wb=%h rd=%0d, required wb=ff80 rd=4",
               wb_regfile_writeback, wb_rd_id);
    end
  endtask

  task automatic test_load_delayed();
    int stall_cycles = 0;
    @(posedge clk); #1;
    drive_load(4'd7, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    if (wb_stall === 1'b1) stall_cycles++;
    // While waiting, a competing MEM instruction must be ignored.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive_alu(16'h5555, 4'd9, 1'b1);
      dmem_rdata = 16'h7F7F;
      @(negedge clk);
      if (wb_stall === 1'b1) stall_cycles++;
    end
    @(posedge clk); #1;
    set_idle();
    dmem_rvalid = 1'b1; dmem_rdata = 16'h0080;
    exp_q.push_back(wr_t'{16'hFF80, 4'd7});
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL load_dly_rvalid_stall: got %b, required 0", wb_stall);
    end
    n_checks++;
    if (stall_cycles != 3) begin
      n_fail++; $display("FAIL load_dly_stall_cycles: got %0d, required 3", stall_cycles);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'hFF80 || wb_rd_id !== 4'd7) begin
      n_fail++;
      $display("FAIL load_dly_signed: got wb=%h rd=%0d, required wb=ff80 rd=7",
               wb_regfile_writeback, wb_rd_id);
    end
    // Unsigned byte: MEM controls change during WAIT; latched copies must win.
    @(posedge clk); #1;
    drive_load(4'd8, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    drive_load(4'hF, 1'b0, 1'b1, 1'b1, 16'h3380);
    exp_q.push_back(wr_t'{16'h0080, 4'd8});
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0080 || wb_rd_id !== 4'd8) begin
      n_fail++;
      $display("FAIL load_dly_unsigned: got wb=%h rd=%0d, required wb=0080 rd=8",
               wb_regfile_writeback, wb_rd_id);
    end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    drive_load(4'd2, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b1) begin
      n_fail++; $display("FAIL to_accept_stall: got %b, required 1", wb_stall);
    end
    for (int i = 0; i < LOAD_TIMEOUT; i++) begin
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      n_checks++;
      if (wb_stall !== 1'b1 || wb_load_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait%0d: got stall=%b to=%b, required stall=1 to=0",
                 i, wb_stall, wb_load_timeout);
      end
    end
    // Late rvalid with nothing outstanding must be ignored.
    @(posedge clk); #1;
    set_idle();
    dmem_rvalid = 1'b1; dmem_rdata = 16'hDEAD;
    @(negedge clk);
    n_checks++;
    if (wb_load_timeout !== 1'b1 || wb_stall !== 1'b0 || wb_regfile_writeback !== 16'h0080) begin
      n_fail++;
      $display("FAIL to_flag: got to=%b stall=%b wb=%h, required to=1 stall=0 wb=0080",
               wb_load_timeout, wb_stall, wb_regfile_writeback);
    end
    @(posedge clk); #1;
    drive_alu(16'h0F0F, 4'd1, 1'b1);
    exp_q.push_back(wr_t'{16'h0F0F, 4'd1});
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0080 || wb_rd_id !== 4'd8) begin
      n_fail++;
      $display("FAIL to_no_write: got wb=%h rd=%0d, required wb=0080 rd=8",
               wb_regfile_writeback, wb_rd_id);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0F0F || wb_load_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky: got wb=%h to=%b, required wb=0f0f to=1",
               wb_regfile_writeback, wb_load_timeout);
    end
  endtask

  task automatic test_suspend_mid_load();
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_load_timeout !== 1'b0) begin
      n_fail++; $display("FAIL susp_rst_clears_to: got %b, required 0", wb_load_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_load(4'd4, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    set_idle();
    // Frozen for longer than the timeout: the counter must not advance.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      suspend_cpu = 1'b1;
      drive_alu(16'h7777, 4'hE, 1'b1);
      @(negedge clk);
      n_checks++;
      if (wb_stall !== 1'b1 || wb_reg_write !== 1'b0 || wb_load_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL susp_frozen%0d: got stall=%b we=%b to=%b, required stall=1 we=0 to=0",
                 i, wb_stall, wb_reg_write, wb_load_timeout);
      end
    end
    @(posedge clk); #1;
    suspend_cpu = 1'b0;
    set_idle();
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 16'hC0DE;
    exp_q.push_back(wr_t'{16'hC0DE, 4'd4});
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL susp_resume_stall: got %b, required 0", wb_stall);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'hC0DE || wb_rd_id !== 4'd4 || wb_load_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL susp_resume_data: got wb=%h rd=%0d to=%b, required wb=c0de rd=4 to=0",
               wb_regfile_writeback, wb_rd_id, wb_load_timeout);
    end
    // A strobe registered just before a freeze is masked while frozen.
    @(posedge clk); #1;
    drive_alu(16'h1111, 4'd2, 1'b1);
    @(posedge clk); #1;
    suspend_cpu = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_reg_write !== 1'b0 || wb_regfile_writeback !== 16'h1111 || wb_rd_id !== 4'd2) begin
      n_fail++;
      $display("FAIL susp_mask_we: got we=%b wb=%h rd=%0d, required we=0 wb=1111 rd=2",
               wb_reg_write, wb_regfile_writeback, wb_rd_id);
    end
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    rst = 1'b1;
    suspend_cpu = 1'b0;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_alu(16'hAAAA, 4'd9, 1'b1);
    exp_q.push_back(wr_t'{16'hAAAA, 4'd9});
    @(posedge clk); #1;
    drive_load(4'd6, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b1 || wb_regfile_writeback !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL rst_pre_wait: got stall=%b wb=%h, required stall=1 wb=aaaa",
               wb_stall, wb_regfile_writeback);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wb_regfile_writeback, wb_rd_id, wb_reg_write, wb_stall, wb_load_timeout} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got wb=%h rd=%0d we=%b stall=%b to=%b, required all 0",
               wb_regfile_writeback, wb_rd_id, wb_reg_write, wb_stall, wb_load_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    dmem_rvalid = 1'b1; dmem_rdata = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_state_idle: got stall=%b, required 0", wb_stall);
    end
    @(posedge clk); #1;
    drive_load(4'd3, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    exp_q.push_back(wr_t'{16'h5A5A, 4'd3});
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h0000) begin
      n_fail++; $display("FAIL rst_stray_rvalid: got %h, required 0000", wb_regfile_writeback);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (wb_regfile_writeback !== 16'h5A5A || wb_rd_id !== 4'd3) begin
      n_fail++;
      $display("FAIL rst_after_load: got wb=%h rd=%0d, required wb=5a5a rd=3",
               wb_regfile_writeback, wb_rd_id);
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    @(posedge clk); #1;
    drive_alu(16'h00AA, 4'd1, 1'b1);
    exp_q.push_back(wr_t'{16'h00AA, 4'd1});
    @(negedge clk);
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_data !== 16'h00AA) begin
      n_fail++;
      $display("FAIL fwd_alu: got valid=%b data=%h, required valid=1 data=00aa",
               fwd_valid, fwd_data);
    end
    @(posedge clk); #1;
    set_idle();
    @(posedge clk); #1;
    suspend_cpu = 1'b1;
    drive_alu(16'h00BB, 4'd2, 1'b1);
    @(negedge clk);
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_suspend: got %b, required 0", fwd_valid);
    end
    @(posedge clk); #1;
    suspend_cpu = 1'b0;
    drive_alu(16'h00CC, 4'd3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_no_write: got %b, required 0", fwd_valid);
    end
    @(posedge clk); #1;
    set_idle();
  endtask
`endif

  initial begin
    set_idle();
    test_reset();
    test_alu_write();
    test_back_to_back();
    test_semaphore();
    test_load_immediate();
    test_load_delayed();
    test_timeout();
    test_suspend_mid_load();
    test_reset_mid_load();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d writes still expected, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
